// File: rtl/user_bram_pkg.sv
// Shared types and constants for the latency-controlled user BRAM.
package user_bram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          LAT_W            = 8;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/user_bram_latency_ctrl_array.sv
// Single-port word-wide SRAM with byte-lane writes and a registered read port.
// The read register only loads on read accesses, so it holds the last read word.
module user_bram_latency_ctrl_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       di,
  output logic [31:0]       dout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  // Byte-enabled write, synchronous read of the addressed word on read accesses
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= di[8*i +: 8];
      end
      if (we == 4'b0000) dout <= mem[addr];
    end
  end

endmodule

// File: rtl/user_bram_latency_ctrl.sv
// Wishbone-side BRAM target: accepts one request, waits LATENCY cycles,
// performs the SRAM access on the edge entering RESP and pulses rsp_ack.
module user_bram_latency_ctrl
  import user_bram_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          LATENCY  = 10,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        req_en,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  output logic        rsp_ack,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy
);

  state_t             state, state_nx;
  logic [LAT_W-1:0]   count, count_nx;

  logic [3:0]         cap_we;
  logic               cap_oor;
  logic [ADDR_W-1:0]  cap_word;
  logic [31:0]        cap_dat;

  logic               rd_vld, rd_err;
  logic [31:0]        mem_dout;

  logic               accept, enter_resp, mem_en;
  logic [3:0]         acc_we;
  logic               acc_oor;
  logic [ADDR_W-1:0]  acc_word;
  logic [31:0]        acc_dat;
  logic               req_oor;

  // Address bits outside the decoded window and below word granularity.
  logic               unused_adr;
  assign unused_adr = ^{req_adr[31:20], req_adr[1:0]};

  // True when any address bit between the window top and bit 19 is set.
  function automatic logic out_of_range(input logic [19:0] adr);
    logic [19:0] hi;
    hi = adr >> (ADDR_W + 2);
    return hi != '0;
  endfunction

  assign req_oor = out_of_range(req_adr[19:0]);
  assign accept  = (state == IDLE) && req_en;

  // With LATENCY=1 the access happens on the accept edge itself, so the live
  // request fields are used in IDLE and the captured ones afterwards.
  assign acc_we   = (state == IDLE) ? req_we : cap_we;
  assign acc_oor  = (state == IDLE) ? req_oor : cap_oor;
  assign acc_word = (state == IDLE) ? req_adr[ADDR_W+1:2] : cap_word;
  assign acc_dat  = (state == IDLE) ? req_dat : cap_dat;

  // Reset gates the enable so a reset edge can never commit a write.
  assign enter_resp = (state_nx == RESP);
  assign mem_en     = enter_resp && !acc_oor && wb_rst_n_i;

  // Next-state and latency counter
  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      IDLE: begin
        if (req_en) begin
          count_nx = LAT_W'(LATENCY - 1);
          state_nx = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!req_en)              state_nx = IDLE;
        else if (count == '0)     state_nx = RESP;
        else                      count_nx = count - 1'b1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control state: FSM, counter, captured control fields, read-result flags
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state   <= IDLE;
      count   <= '0;
      cap_we  <= '0;
      cap_oor <= 1'b0;
      rd_vld  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (accept) begin
        cap_we  <= req_we;
        cap_oor <= req_oor;
      end
      if (enter_resp && (acc_we == 4'b0000)) begin
        rd_vld <= 1'b1;
        rd_err <= acc_oor;
      end
    end
  end

  // Captured datapath fields; later changes on the request bus are ignored
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      cap_word <= req_adr[ADDR_W+1:2];
      cap_dat  <= req_dat;
    end
  end

  user_bram_latency_ctrl_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk  (wb_clk_i),
    .en   (mem_en),
    .we   (acc_we),
    .addr (acc_word),
    .di   (acc_dat),
    .dout (mem_dout)
  );

  assign rsp_ack = (state == RESP);
  assign rsp_err = (state == RESP) && cap_oor;
  assign busy    = (state != IDLE);
  assign rsp_dat = rd_err ? ERR_DATA : (rd_vld ? mem_dout : 32'h0000_0000);

endmodule

// File: tb/tb_user_bram_latency_ctrl.sv
// Scoreboard bench for user_bram_latency_ctrl: a default build (ADDR_W=10,
// LATENCY=10) and a LATENCY=1 build (ADDR_W=4) share clock and reset.
module tb_user_bram_latency_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_en0, req_en1;
  logic [3:0]  req_we0, req_we1;
  logic [31:0] req_adr0, req_adr1, req_dat0, req_dat1;
  logic        ack0, ack1, err0, err1, busy0, busy1;
  logic [31:0] dat0, dat1;

  user_bram_latency_ctrl dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .req_en(req_en0), .req_we(req_we0),
    .req_adr(req_adr0), .req_dat(req_dat0), .rsp_ack(ack0), .rsp_dat(dat0),
    .rsp_err(err0), .busy(busy0));

  user_bram_latency_ctrl #(.ADDR_W(4), .LATENCY(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .req_en(req_en1), .req_we(req_we1),
    .req_adr(req_adr1), .req_dat(req_dat1), .rsp_ack(ack1), .rsp_dat(dat1),
    .rsp_err(err1), .busy(busy1));

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model0 [0:1023];
  logic [31:0] model1 [0:15];
  logic [31:0] last_rd0, last_rd1;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic get_ack(input bit sel);  return sel ? ack1  : ack0;  endfunction
  function automatic logic get_err(input bit sel);  return sel ? err1  : err0;  endfunction
  function automatic logic get_busy(input bit sel); return sel ? busy1 : busy0; endfunction
  function automatic logic [31:0] get_dat(input bit sel); return sel ? dat1 : dat0; endfunction

  task automatic drive(input bit sel, input logic en, input logic [3:0] we,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (sel) begin req_en1 = en; req_we1 = we; req_adr1 = adr; req_dat1 = dat; end
    else     begin req_en0 = en; req_we0 = we; req_adr0 = adr; req_dat0 = dat; end
  endtask

  // Reference model: update memory and compute the response for one request.
  task automatic push_exp(input bit sel, input logic [3:0] we, input logic [31:0] adr,
                          input logic [31:0] dat);
    exp_t        e;
    int          aw;
    logic        oor;
    int          idx;
    logic [31:0] w;
    aw  = sel ? 4 : 10;
    oor = ((adr[19:0] >> (aw + 2)) != 20'd0);
    idx = int'((adr >> 2) & ((32'd1 << aw) - 1));
    if (!oor && we != 4'b0000) begin
      w = sel ? model1[idx] : model0[idx];
      for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = dat[8*i +: 8];
      if (sel) model1[idx] = w; else model0[idx] = w;
    end
    if (we == 4'b0000) begin
      if (sel) last_rd1 = oor ? 32'h0 : model1[idx];
      else     last_rd0 = oor ? 32'h0 : model0[idx];
    end
    e.err = oor;
    e.dat = sel ? last_rd1 : last_rd0;
    sb.push_back(e);
  endtask

  // One full transaction: accept, scramble the bus, wait for ack, score it.
  task automatic run_txn(input bit sel, input logic [3:0] we, input logic [31:0] adr,
                         input logic [31:0] dat, input int exp_lat, input string name);
    int   lat;
    int   bcy;
    exp_t e;
    @(negedge clk);
    drive(sel, 1'b1, we, adr, dat);
    push_exp(sel, we, adr, dat);
    @(posedge clk); #1;
    drive(sel, 1'b1, ~we, adr ^ 32'h0000_0004, ~dat);
    lat = -1;
    bcy = 0;
    for (int k = 0; k < 40; k++) begin
      if (get_busy(sel) === 1'b1) bcy++;
      if (get_ack(sel) === 1'b1) begin lat = k; break; end
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 4'b0000, 32'h0, 32'h0);
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d, want %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (bcy !== exp_lat + 1) begin
      n_err++; $display("FAIL %s busy_cycles: got %0d, want %0d", name, bcy, exp_lat + 1);
    end
    e = sb.pop_front();
    n_vec++;
    if (get_err(sel) !== e.err) begin
      n_err++; $display("FAIL %s rsp_err: got %b, want %b", name, get_err(sel), e.err);
    end
    n_vec++;
    if (get_dat(sel) !== e.dat) begin
      n_err++; $display("FAIL %s rsp_dat: got %h, want %h", name, get_dat(sel), e.dat);
    end
    @(posedge clk); #1;
    n_vec++;
    if (get_busy(sel) !== 1'b0 || get_ack(sel) !== 1'b0) begin
      n_err++; $display("FAIL %s return_idle: got busy=%b ack=%b, want 0 0",
                        name, get_busy(sel), get_ack(sel));
    end
  endtask

  // Watch for a stray ack over a window of cycles.
  task automatic expect_no_ack(input bit sel, input int cycles, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (get_ack(sel) !== 1'b0) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++; $display("FAIL %s no_ack: got %0d ack cycles, want 0", name, seen);
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if ({ack0, err0, busy0, dat0} !== 35'd0) begin
      n_err++; $display("FAIL reset_dut0: got ack=%b err=%b busy=%b dat=%h, want 0",
                        ack0, err0, busy0, dat0);
    end
    n_vec++;
    if ({ack1, err1, busy1, dat1} !== 35'd0) begin
      n_err++; $display("FAIL reset_dut1: got ack=%b err=%b busy=%b dat=%h, want 0",
                        ack1, err1, busy1, dat1);
    end
  endtask

  task automatic test_write_read();
    run_txn(0, 4'hF, 32'h0000_0000, 32'hA5A5_1234, 10, "write_full");
    run_txn(0, 4'h0, 32'h0000_0000, 32'h0, 10, "read_full");
    run_txn(0, 4'hF, 32'h0000_0FFC, 32'h0BAD_F00D, 10, "write_top");
    run_txn(0, 4'h0, 32'h0000_0FFC, 32'h0, 10, "read_top");
  endtask

  task automatic test_byte_lane();
    run_txn(0, 4'b0010, 32'h0000_0000, 32'h0000_FF00, 10, "write_lane1");
    run_txn(0, 4'h0, 32'h0000_0000, 32'h0, 10, "read_lane1");
    run_txn(0, 4'b1001, 32'h0000_0000, 32'h7700_0088, 10, "write_lane03");
    run_txn(0, 4'h0, 32'h0000_0000, 32'h0, 10, "read_lane03");
  endtask

  task automatic test_abort();
    run_txn(0, 4'hF, 32'h0000_0004, 32'h1111_2222, 10, "abort_prefill");
    @(negedge clk);
    drive(0, 1'b1, 4'hF, 32'h0000_0004, 32'hFFFF_FFFF);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    expect_no_ack(0, 20, "abort");
    run_txn(0, 4'h0, 32'h0000_0004, 32'h0, 10, "abort_readback");
  endtask

  task automatic test_out_of_range();
    run_txn(0, 4'h0, 32'h0000_1000, 32'h0, 10, "oor_read");
    run_txn(0, 4'hF, 32'h0008_0000, 32'hDEAD_BEEF, 10, "oor_write");
    run_txn(0, 4'hF, 32'h0000_1000, 32'h5555_AAAA, 10, "oor_alias_write");
    run_txn(0, 4'h0, 32'h0000_0000, 32'h0, 10, "oor_check_word0");
    run_txn(0, 4'h0, 32'h0010_0000, 32'h0, 10, "high_bit_read");
  endtask

  task automatic test_back_to_back();
    int   gap;
    exp_t e;
    @(negedge clk);
    drive(0, 1'b1, 4'h0, 32'h0000_0004, 32'h0);
    push_exp(0, 4'h0, 32'h0000_0004, 32'h0);
    push_exp(0, 4'h0, 32'h0000_0004, 32'h0);
    gap = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ack0 === 1'b1) break;
    end
    e = sb.pop_front();
    n_vec++;
    if (ack0 !== 1'b1 || dat0 !== e.dat) begin
      n_err++; $display("FAIL b2b_first: got ack=%b dat=%h, want 1 %h", ack0, dat0, e.dat);
    end
    for (int k = 1; k < 40; k++) begin
      @(posedge clk); #1;
      if (ack0 === 1'b1) begin gap = k; break; end
    end
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    e = sb.pop_front();
    n_vec++;
    if (gap !== 12) begin
      n_err++; $display("FAIL b2b_gap: got %0d, want 12", gap);
    end
    n_vec++;
    if (dat0 !== e.dat) begin
      n_err++; $display("FAIL b2b_second_dat: got %h, want %h", dat0, e.dat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    run_txn(0, 4'hF, 32'h0000_0008, 32'hCAFE_0000, 10, "rst_prefill");
    @(negedge clk);
    drive(0, 1'b1, 4'hF, 32'h0000_0008, 32'h1234_5678);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ack0, err0, busy0, dat0} !== 35'd0) begin
      n_err++; $display("FAIL rst_mid_wait: got ack=%b err=%b busy=%b dat=%h, want 0",
                        ack0, err0, busy0, dat0);
    end
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    last_rd0 = 32'h0;
    last_rd1 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_ack(0, 15, "rst_mid_wait");
    run_txn(0, 4'h0, 32'h0000_0008, 32'h0, 10, "rst_readback");
  endtask

  task automatic test_latency_one();
    run_txn(1, 4'hF, 32'h0000_0004, 32'h0000_00AB, 0, "lat1_write");
    run_txn(1, 4'b0100, 32'h0000_0004, 32'h00CD_0000, 0, "lat1_write_lane2");
    run_txn(1, 4'h0, 32'h0000_0004, 32'h0, 0, "lat1_read");
    run_txn(1, 4'h0, 32'h0000_0040, 32'h0, 0, "lat1_oor_read");
  endtask

  initial begin
    rst_n    = 1'b0;
    last_rd0 = 32'h0;
    last_rd1 = 32'h0;
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_write_read();
    test_byte_lane();
    test_abort();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_wait();
    test_latency_one();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
